// File: rtl/ublock_mask_pkg.sv
// ublock_mask_pkg: shared width, PRNG seed/taps, FSM encoding and LFSR step for the masked uBlock wrapper
package ublock_mask_pkg;
  localparam int W = 128;
  localparam logic [W-1:0] SEED_DEFAULT_C = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam int TAP_A = 128;
  localparam int TAP_B = 126;
  localparam int TAP_C = 101;
  localparam int TAP_D = 99;
  typedef enum logic [2:0] {S_IDLE, S_MASK, S_START, S_BUSY, S_OUT} state_t;
  // W serial Fibonacci steps unrolled into one combinational next-state
  function automatic logic [W-1:0] lfsr_adv(input logic [W-1:0] s);
    logic [W-1:0] v;
    v = s;
    for (int i = 0; i < W; i++)
      v = {v[W-2:0], v[TAP_A-1] ^ v[TAP_B-1] ^ v[TAP_C-1] ^ v[TAP_D-1]};
    return v;
  endfunction
endpackage

// File: rtl/ublock_prng128.sv
// ublock_prng128: free-running 128-bit mask generator, 128 LFSR steps per clock.
// Define UBLOCK_RESEED_EN to add the seed_we/seed load port.
module ublock_prng128
  import ublock_mask_pkg::*;
#(
  parameter logic [W-1:0] SEED = SEED_DEFAULT_C
) (
  input  logic         clk,
  input  logic         rstn,
`ifdef UBLOCK_RESEED_EN
  input  logic         seed_we,
  input  logic [W-1:0] seed,
`endif
  output logic [W-1:0] rnd
);
  logic [W-1:0] r_lfsr;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_lfsr <= SEED;
`ifdef UBLOCK_RESEED_EN
    else if (seed_we) r_lfsr <= (seed == '0) ? SEED : seed;
`endif
    else r_lfsr <= lfsr_adv(r_lfsr);
  assign rnd = r_lfsr;
endmodule

// File: rtl/ublock_mask_wrapper.sv
// ublock_mask_wrapper: splits plaintext/key into fresh Boolean shares, sequences the masked uBlock core, recombines ciphertext.
// Define UBLOCK_RESEED_EN to expose seed_we/seed for PRNG reseeding.
module ublock_mask_wrapper
  import ublock_mask_pkg::*;
#(
  parameter logic [W-1:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
  input  logic         clk,
  input  logic         rstn,
`ifdef UBLOCK_RESEED_EN
  input  logic         seed_we,
  input  logic [W-1:0] seed,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_plain,
  input  logic [W-1:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_cipher,
  output logic [W-1:0] core_plain0,
  output logic [W-1:0] core_plain1,
  output logic [W-1:0] core_key0,
  output logic [W-1:0] core_key1,
  output logic         core_start,
  input  logic         core_occupied,
  input  logic         core_done,
  input  logic [W-1:0] core_cipher0,
  input  logic [W-1:0] core_cipher1
);
  state_t r_state, w_next;
  logic [W-1:0] w_rnd, r_key_q, r_plain0, r_plain1, r_key0, r_key1, r_cipher;
  ublock_prng128 #(.SEED(SEED_DEFAULT)) u_prng (
    .clk    (clk),
    .rstn   (rstn),
`ifdef UBLOCK_RESEED_EN
    .seed_we(seed_we),
    .seed   (seed),
`endif
    .rnd    (w_rnd)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = in_valid ? S_MASK : S_IDLE;
      S_MASK:  w_next = S_START;
      S_START: w_next = core_occupied ? S_START : S_BUSY;
      S_BUSY:  w_next = core_done ? S_OUT : S_BUSY;
      S_OUT:   w_next = out_ready ? S_IDLE : S_OUT;
      default: w_next = S_IDLE;
    endcase
  end
  // plaintext and key draw masks on consecutive cycles so their shares never reuse r
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_key_q  <= '0;
      r_plain0 <= '0;
      r_plain1 <= '0;
      r_key0   <= '0;
      r_key1   <= '0;
      r_cipher <= '0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_plain1 <= w_rnd;
        r_plain0 <= in_plain ^ w_rnd;
        r_key_q  <= in_key;
      end
      if (r_state == S_MASK) begin
        r_key1  <= w_rnd;
        r_key0  <= r_key_q ^ w_rnd;
        r_key_q <= '0;
      end
      if (r_state == S_BUSY && core_done) r_cipher <= core_cipher0 ^ core_cipher1;
    end
  assign in_ready    = rstn && (r_state == S_IDLE);
  assign out_valid   = (r_state == S_OUT);
  assign core_start  = (r_state == S_START) && !core_occupied;
  assign out_cipher  = r_cipher;
  assign core_plain0 = r_plain0;
  assign core_plain1 = r_plain1;
  assign core_key0   = r_key0;
  assign core_key1   = r_key1;
endmodule
